// File: rtl/pixel_serializer_pkg.sv
// Shared PPU constants and types for the pixel serializer slice.
package pixel_serializer_pkg;

    localparam int PIXEL_W         = 8;
    localparam int GROUP_PIXELS    = 8;
    localparam int GROUP_W         = PIXEL_W * GROUP_PIXELS;
    localparam int COORD_W         = 8;
    localparam int DEF_LINE_PIXELS = 256;
    localparam int DEF_FRAME_LINES = 240;
    localparam int CNT_W           = $clog2(GROUP_PIXELS + 1);

    typedef logic [PIXEL_W-1:0] pixel_t;
    typedef logic [GROUP_W-1:0] group_t;
    typedef logic [COORD_W-1:0] coord_t;
    typedef logic [CNT_W-1:0]   cnt_t;

endpackage

// File: rtl/pixel_serializer_if.sv
// Group input and pixel output handshakes of the serializer; master is the serializer side.
interface pixel_serializer_if;
    import pixel_serializer_pkg::*;

    logic   group_valid;
    group_t group_data;
    logic   group_ready;
    logic   pix_valid;
    pixel_t pix_data;
    coord_t pix_x;
    coord_t pix_y;
    logic   pix_ready;
    logic   line_done;
    logic   frame_done;

    modport master (
        input  group_valid, group_data, pix_ready,
        output group_ready, pix_valid, pix_data, pix_x, pix_y, line_done, frame_done
    );

    modport slave (
        output group_valid, group_data, pix_ready,
        input  group_ready, pix_valid, pix_data, pix_x, pix_y, line_done, frame_done
    );

endinterface

// File: rtl/pixel_serializer_coord.sv
// Scan position counters: column/row with wrap and end-of-line/end-of-frame pulses.
module pixel_coord_counter
    import pixel_serializer_pkg::*;
#(
    parameter int LINE_PIXELS = DEF_LINE_PIXELS,
    parameter int FRAME_LINES = DEF_FRAME_LINES
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   clear,
    input  logic   advance,
    output coord_t x,
    output coord_t y,
    output logic   line_done,
    output logic   frame_done
);

    logic last_col;
    logic last_row;

    assign last_col   = (x == coord_t'(LINE_PIXELS - 1));
    assign last_row   = (y == coord_t'(FRAME_LINES - 1));
    assign line_done  = advance && last_col;
    assign frame_done = line_done && last_row;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            x <= '0;
            y <= '0;
        end else if (advance) begin
            if (last_col) begin
                x <= '0;
                y <= last_row ? '0 : y + coord_t'(1);
            end else begin
                x <= x + coord_t'(1);
            end
        end
    end

endmodule

// File: rtl/pixel_serializer.sv
// Serializes 8-pixel groups (byte 7 first) into a pixel stream with scan coordinates.
module pixel_serializer
    import pixel_serializer_pkg::*;
#(
    parameter int LINE_PIXELS = DEF_LINE_PIXELS,
    parameter int FRAME_LINES = DEF_FRAME_LINES
) (
    input logic clk,
    input logic rst,
    input logic sof,
    pixel_serializer_if.master bus
);

    localparam cnt_t FULL_CNT = cnt_t'(GROUP_PIXELS);

    group_t shift_data;
    group_t hold_data;
    cnt_t   shift_cnt;
    logic   hold_full;

    logic pix_fire;
    logic group_fire;
    logic last_out;
    logic shift_free;
    logic advance;

    assign bus.pix_valid   = (shift_cnt != '0);
    assign bus.pix_data    = bus.pix_valid ? shift_data[GROUP_W-1 -: PIXEL_W] : '0;
    assign bus.group_ready = !hold_full && !sof && !rst;

    assign pix_fire   = bus.pix_valid && bus.pix_ready;
    assign group_fire = bus.group_valid && bus.group_ready;
    assign last_out   = pix_fire && (shift_cnt == cnt_t'(1));
    // SHIFT can take new content when it is empty or drains its final pixel this cycle.
    assign shift_free = (shift_cnt == '0) || last_out;
    // A pixel leaving in a sof cycle is part of the discarded frame.
    assign advance    = pix_fire && !sof && !rst;

    always_ff @(posedge clk) begin
        if (rst || sof) begin
            shift_cnt <= '0;
            hold_full <= 1'b0;
        end else if (shift_free) begin
            if (hold_full) begin
                shift_cnt <= FULL_CNT;
                hold_full <= 1'b0;
            end else if (group_fire) begin
                shift_cnt <= FULL_CNT;
            end else if (pix_fire) begin
                shift_cnt <= '0;
            end
        end else begin
            if (pix_fire)
                shift_cnt <= shift_cnt - cnt_t'(1);
            if (group_fire)
                hold_full <= 1'b1;
        end
    end

    // NOTE: data registers carry no reset; shift_cnt/hold_full qualify them and pix_data is gated.
    always_ff @(posedge clk) begin
        if (shift_free) begin
            if (hold_full)
                shift_data <= hold_data;
            else if (group_fire)
                shift_data <= bus.group_data;
            else if (pix_fire)
                shift_data <= shift_data << PIXEL_W;
        end else if (pix_fire) begin
            shift_data <= shift_data << PIXEL_W;
        end
        if (!shift_free && group_fire)
            hold_data <= bus.group_data;
    end

    pixel_coord_counter #(
        .LINE_PIXELS (LINE_PIXELS),
        .FRAME_LINES (FRAME_LINES)
    ) u_coord (
        .clk        (clk),
        .rst        (rst),
        .clear      (sof),
        .advance    (advance),
        .x          (bus.pix_x),
        .y          (bus.pix_y),
        .line_done  (bus.line_done),
        .frame_done (bus.frame_done)
    );

endmodule

// File: tb/tb_pixel_serializer.sv
// Self-checking bench: queue-of-pixels reference model, directed steps plus random traffic.
module tb_pixel_serializer;
    import pixel_serializer_pkg::*;

    localparam int LP = 256;
    localparam int FL = 240;

    logic clk = 1'b0;
    logic rst;
    logic sof;

    always #5 clk = ~clk;

    pixel_serializer_if bus();

    pixel_serializer #(
        .LINE_PIXELS (LP),
        .FRAME_LINES (FL)
    ) dut (
        .clk (clk),
        .rst (rst),
        .sof (sof),
        .bus (bus)
    );

    int     total = 0;
    int     bad   = 0;
    pixel_t q[$];
    int     mx = 0;
    int     my = 0;
    int     line_cnt = 0;
    int     frame_cnt = 0;
    int     groups_acc = 0;
    group_t ga;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: compare outputs against the model mid-cycle, then advance the model at the edge.
    task automatic tick();
        bit     exp_gr, exp_fire, exp_line, exp_frame, gv;
        group_t gd;
        pixel_t head;
        @(negedge clk);
        exp_gr    = (q.size() <= GROUP_PIXELS) && !sof && !rst;
        exp_fire  = (q.size() > 0) && bus.pix_ready && !sof && !rst;
        exp_line  = exp_fire && (mx == LP - 1);
        exp_frame = exp_line && (my == FL - 1);
        head      = (q.size() > 0) ? q[0] : '0;
        gv        = bus.group_valid;
        gd        = bus.group_data;
        check("pix_valid", bus.pix_valid, q.size() > 0);
        check("group_ready", bus.group_ready, exp_gr);
        check("pix_data", bus.pix_data, head);
        if (q.size() > 0) begin
            check("pix_x", bus.pix_x, mx);
            check("pix_y", bus.pix_y, my);
        end
        check("line_done", bus.line_done, exp_line);
        check("frame_done", bus.frame_done, exp_frame);
        if (bus.line_done)  line_cnt++;
        if (bus.frame_done) frame_cnt++;
        @(posedge clk);
        if (rst || sof) begin
            q.delete();
            mx = 0;
            my = 0;
        end else begin
            if (exp_fire) begin
                void'(q.pop_front());
                mx++;
                if (mx == LP) begin
                    mx = 0;
                    my = (my + 1) % FL;
                end
            end
            if (gv && exp_gr) begin
                groups_acc++;
                for (int k = GROUP_PIXELS - 1; k >= 0; k--)
                    q.push_back(gd[k*PIXEL_W +: PIXEL_W]);
            end
        end
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        rst             = 1'b1;
        sof             = 1'b0;
        bus.group_valid = 1'b0;
        bus.group_data  = '0;
        bus.pix_ready   = 1'b0;
        @(posedge clk);
        #1;
        tick();

        // Reset state
        check("rst_pix_valid", bus.pix_valid, 0);
        check("rst_pix_data", bus.pix_data, 0);
        check("rst_line_done", bus.line_done, 0);
        check("rst_frame_done", bus.frame_done, 0);
        rst = 1'b0;
        #1;
        check("rst_group_ready", bus.group_ready, 1);

        // Single group, byte 7 first, one cycle latency
        bus.group_valid = 1'b1;
        bus.group_data  = 64'h0706050403020100;
        bus.pix_ready   = 1'b1;
        tick();
        bus.group_valid = 1'b0;
        check("lat_valid", bus.pix_valid, 1);
        check("lat_byte7", bus.pix_data, 8'h07);
        check("lat_x", bus.pix_x, 0);
        ticks(10);

        // Backpressure with HOLD filling up
        ga              = {$urandom, $urandom};
        bus.group_valid = 1'b1;
        bus.group_data  = ga;
        tick();
        bus.group_data  = {$urandom, $urandom};
        ticks(2);
        bus.pix_ready   = 1'b0;
        bus.group_data  = {$urandom, $urandom};
        ticks(4);
        check("bp_group_ready", bus.group_ready, 0);
        check("bp_frozen_byte5", bus.pix_data, ga[47:40]);
        bus.pix_ready   = 1'b1;
        bus.group_valid = 1'b0;
        ticks(20);

        // sof mid-group with a group offered
        bus.group_valid = 1'b1;
        bus.group_data  = {$urandom, $urandom};
        ticks(3);
        sof             = 1'b1;
        bus.group_data  = {$urandom, $urandom};
        check("sof_group_ready", bus.group_ready, 0);
        tick();
        sof             = 1'b0;
        bus.group_valid = 1'b0;
        check("sof_flush", bus.pix_valid, 0);
        bus.group_valid = 1'b1;
        bus.group_data  = {$urandom, $urandom};
        tick();
        bus.group_valid = 1'b0;
        check("sof_x0", bus.pix_x, 0);
        check("sof_y0", bus.pix_y, 0);
        ticks(10);

        // Random traffic
        for (int i = 0; i < 800; i++) begin
            bus.group_valid = ($urandom_range(0, 3) != 0);
            bus.group_data  = {$urandom, $urandom};
            bus.pix_ready   = ($urandom_range(0, 3) != 0);
            sof             = ($urandom_range(0, 63) == 0);
            tick();
        end
        sof             = 1'b0;
        bus.group_valid = 1'b0;
        bus.pix_ready   = 1'b1;
        ticks(20);

        // rst with HOLD full and sof together
        bus.pix_ready   = 1'b0;
        bus.group_valid = 1'b1;
        bus.group_data  = {$urandom, $urandom};
        ticks(3);
        check("full_group_ready", bus.group_ready, 0);
        rst = 1'b1;
        sof = 1'b1;
        tick();
        rst             = 1'b0;
        sof             = 1'b0;
        bus.group_valid = 1'b0;
        #1;
        check("rst2_pix_valid", bus.pix_valid, 0);
        check("rst2_pix_data", bus.pix_data, 0);
        check("rst2_group_ready", bus.group_ready, 1);
        check("rst2_line_done", bus.line_done, 0);
        check("rst2_frame_done", bus.frame_done, 0);

        // Full frame at one pixel per clock
        sof = 1'b1;
        tick();
        sof           = 1'b0;
        line_cnt      = 0;
        frame_cnt     = 0;
        groups_acc    = 0;
        bus.pix_ready = 1'b1;
        for (int c = 0; c < 70000 && groups_acc < FL * LP / GROUP_PIXELS; c++) begin
            bus.group_valid = 1'b1;
            bus.group_data  = {$urandom, $urandom};
            tick();
        end
        check("stream_groups", groups_acc, FL * LP / GROUP_PIXELS);
        bus.group_valid = 1'b0;
        ticks(20);
        check("frame_lines", line_cnt, FL);
        check("frame_once", frame_cnt, 1);
        bus.group_valid = 1'b1;
        bus.group_data  = {$urandom, $urandom};
        tick();
        bus.group_valid = 1'b0;
        check("wrap_x0", bus.pix_x, 0);
        check("wrap_y0", bus.pix_y, 0);
        ticks(10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
